// File: rtl/result_uart_tx.sv
// Result interface to UART: queues letter bytes, latches finished words, and
// serialises them 8N1 (letters raw, words framed as 0x02, bytes, 0x03).
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_letter_valid,
  input  logic [7:0]                     i_letter,
  input  logic                           i_finished,
  input  logic [119:0]                   i_word,
  input  logic [3:0]                     i_length,
  output logic                           o_tx,
  output logic                           o_busy,
  output logic                           o_drop,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  state_t          state_n;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            push;
  logic            pop;
  logic            letter_drop;

  logic            finished_q;
  logic            rise;
  logic            pending;
  logic            word_drop;
  logic [119:0]    word_q;
  logic [3:0]      len_q;
  logic [4:0]      widx;
  logic [4:0]      last_idx;
  logic [3:0]      byte_sel;
  logic [7:0]      word_byte;
  logic            cur_word;
  logic            word_done;

  logic [7:0]      shreg;
  logic [BW-1:0]   baud;
  logic [2:0]      bitcnt;
  logic            baud_end;
  logic            load_word;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign push        = i_letter_valid && !full;
  assign letter_drop = i_letter_valid && full;
  assign rise        = i_finished && !finished_q;
  assign word_drop   = rise && pending;
  assign baud_end    = (baud == BW'(CLKS_PER_BIT - 1));
  assign last_idx    = {1'b0, len_q} + 5'd1;
  assign word_done   = (state == STOP) && baud_end && cur_word && (widx == last_idx);

  // Letter FIFO: a full FIFO rejects the push even if a pop happens on the same edge.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_letter;
  end

  // Word capture on the rising edge of i_finished; pending holds until 0x03 has left.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      finished_q <= 1'b0;
      pending    <= 1'b0;
      word_q     <= '0;
      len_q      <= '0;
      o_drop     <= 1'b0;
    end else begin
      finished_q <= i_finished;
      o_drop     <= letter_drop || word_drop;
      if (rise && !pending) begin
        word_q  <= i_word;
        len_q   <= i_length;
        pending <= 1'b1;
      end else if (word_done) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    byte_sel = widx[3:0] - 4'd1;
    if (widx == 5'd0)          word_byte = 8'h02;
    else if (widx == last_idx) word_byte = 8'h03;
    else                       word_byte = word_q[{byte_sel, 3'b000} +: 8];
  end

  always_comb begin
    state_n   = state;
    load_word = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          load_word = 1'b1;
          state_n   = START;
        end else if (count != '0) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START:   if (baud_end) state_n = DATA;
      DATA:    if (baud_end && bitcnt == 3'd7) state_n = STOP;
      STOP:    if (baud_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state    <= IDLE;
      baud     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      widx     <= '0;
      cur_word <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state || baud_end) baud <= '0;
      else                              baud <= baud + BW'(1);
      if (load_word)                   shreg <= word_byte;
      else if (pop)                    shreg <= mem[rd_ptr];
      else if (state == DATA && baud_end) shreg <= {1'b0, shreg[7:1]};
      if (state == DATA && baud_end) bitcnt <= bitcnt + 3'd1;
      if (state == IDLE && state_n == START) cur_word <= load_word;
      if (state == STOP && baud_end && cur_word) begin
        if (widx == last_idx) widx <= '0;
        else                  widx <= widx + 5'd1;
      end
    end
  end

  always_comb begin
    o_tx = 1'b1;
    case (state)
      START:   o_tx = 1'b0;
      DATA:    o_tx = shreg[0];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_busy       = (count != '0) || pending || (state != IDLE);
  assign o_fifo_count = count;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: a transaction-level model predicts the byte stream,
// line level, busy, drop and FIFO occupancy every cycle; a UART receiver decodes o_tx.
module tb_result_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lv = 1'b0;
  logic [7:0]    letter = '0;
  logic          fin = 1'b0;
  logic [119:0]  word = '0;
  logic [3:0]    len = '0;
  logic          tx;
  logic          busy;
  logic          drop;
  logic [CW-1:0] fcount;

  always #5 clk = ~clk;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst), .i_letter_valid(lv), .i_letter(letter),
    .i_finished(fin), .i_word(word), .i_length(len),
    .o_tx(tx), .o_busy(busy), .o_drop(drop), .o_fifo_count(fcount)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model (edge-indexed, queue based) ----------------
  logic [7:0] m_lq[$];
  logic [7:0] m_pq[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         m_tx_end  = -1;
  int         m_pkt_end = -1;
  int         m_start   = -1000000;
  logic [7:0] m_cur     = '0;
  logic       m_fin_q   = 1'b0;
  logic       m_drop    = 1'b0;
  int         cyc       = 0;

  always @(posedge clk) begin
    int   lpre;
    logic pend;
    logic ldrop;
    logic wdrop;
    if (rst) begin
      m_lq.delete();
      m_pq.delete();
      exp_q.delete();
      m_tx_end  = -1;
      m_pkt_end = -1;
      m_start   = -1000000;
      m_fin_q   = 1'b0;
      m_drop    = 1'b0;
    end else begin
      lpre  = m_lq.size();
      pend  = (m_pq.size() != 0) || (cyc <= m_pkt_end);
      ldrop = 1'b0;
      wdrop = 1'b0;
      if (cyc > m_tx_end) begin
        if (m_pq.size() != 0) begin
          m_cur    = m_pq.pop_front();
          m_start  = cyc;
          m_tx_end = cyc + 10 * CPB;
          exp_q.push_back(m_cur);
          if (m_pq.size() == 0) m_pkt_end = m_tx_end;
        end else if (m_lq.size() != 0) begin
          m_cur    = m_lq.pop_front();
          m_start  = cyc;
          m_tx_end = cyc + 10 * CPB;
          exp_q.push_back(m_cur);
        end
      end
      if (lv) begin
        if (lpre == DEPTH) ldrop = 1'b1;
        else               m_lq.push_back(letter);
      end
      if (fin && !m_fin_q) begin
        if (pend) wdrop = 1'b1;
        else begin
          m_pq.push_back(8'h02);
          for (int k = 0; k < int'(len); k++) m_pq.push_back(word[8*k +: 8]);
          m_pq.push_back(8'h03);
        end
      end
      m_fin_q = fin;
      m_drop  = ldrop || wdrop;
    end
    cyc++;
  end

  function automatic logic exp_tx();
    int off;
    off = (cyc - 1) - m_start;
    if (off < 0 || off >= 10 * CPB) return 1'b1;
    if (off < CPB) return 1'b0;
    if (off >= 9 * CPB) return 1'b1;
    return m_cur[off / CPB - 1];
  endfunction

  function automatic logic exp_busy();
    return (m_lq.size() != 0) || (m_pq.size() != 0) ||
           ((cyc - 1) < m_pkt_end) || ((cyc - 1) < m_tx_end);
  endfunction

  // ---------------- UART receiver on the line ----------------
  int         rx_cnt = 0;
  logic       rx_on  = 1'b0;
  logic [7:0] rx_sh  = '0;

  always @(negedge clk) begin
    if (rst) begin
      rx_on = 1'b0;
      rx_q.delete();
    end else if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        rx_on = 1'b0;
        if (tx == 1'b1) rx_q.push_back(rx_sh);
      end else if (rx_cnt >= CPB + CPB / 2 && ((rx_cnt - CPB / 2) % CPB) == 0) begin
        rx_sh = {tx, rx_sh[7:1]};
      end
    end
  end

  // ---------------- driver helpers ----------------
  int drop_seen = 0;
  int peak      = 0;
  int cmp_i     = 0;

  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      check_eq("tx_line", tx, exp_tx());
      check_eq("busy", busy, exp_busy());
      check_eq("fifo_count", fcount, m_lq.size());
      check_eq("drop", drop, m_drop);
      if (drop) drop_seen++;
      if (int'(fcount) > peak) peak = int'(fcount);
    end
  endtask

  task automatic send_letter(input logic [7:0] b);
    lv = 1'b1;
    letter = b;
    tick();
    lv = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || m_lq.size() != 0 || m_pq.size() != 0 || (cyc - 1) < m_tx_end) && n < 3000) begin
      tick();
      n++;
    end
    check_eq("drain_in_budget", (n < 3000), 1);
    repeat (4) tick();
  endtask

  task automatic compare_streams();
    check_eq("stream_len", rx_q.size(), exp_q.size());
    for (int i = cmp_i; i < exp_q.size() && i < rx_q.size(); i++)
      check_eq("stream_byte", rx_q[i], exp_q[i]);
    cmp_i = exp_q.size();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_drop", drop, 0);
    check_eq("rst_count", fcount, 0);
    rst = 1'b0;
    tick();

    // single letter
    d0 = drop_seen; r0 = rx_q.size();
    send_letter(8'h41);
    drain();
    compare_streams();
    check_eq("t1_nbytes", rx_q.size() - r0, 1);
    check_eq("t1_byte", rx_q[r0], 8'h41);
    check_eq("t1_drops", drop_seen - d0, 0);

    // held-high finished yields one packet
    r0 = rx_q.size();
    word = '0; word[7:0] = 8'h48; word[15:8] = 8'h49; len = 4'd2; fin = 1'b1;
    repeat (200) tick();
    fin = 1'b0;
    drain();
    compare_streams();
    check_eq("t2_nbytes", rx_q.size() - r0, 4);
    check_eq("t2_b0", rx_q[r0], 8'h02);
    check_eq("t2_b3", rx_q[r0+3], 8'h03);

    // FIFO overflow
    d0 = drop_seen; r0 = rx_q.size(); peak = 0;
    for (int i = 0; i < 20; i++) begin
      lv = 1'b1;
      letter = 8'(i);
      tick();
    end
    lv = 1'b0;
    drain();
    compare_streams();
    check_eq("t3_nbytes", rx_q.size() - r0, 17);
    check_eq("t3_last", rx_q[r0+16], 8'h10);
    check_eq("t3_drops", drop_seen - d0, 3);
    check_eq("t3_peak", peak, 16);

    // word beats letter arriving the same cycle
    r0 = rx_q.size();
    word[7:0] = 8'h61; len = 4'd1; lv = 1'b1; letter = 8'h55; fin = 1'b1;
    tick();
    lv = 1'b0;
    tick();
    fin = 1'b0;
    drain();
    compare_streams();
    check_eq("t4_nbytes", rx_q.size() - r0, 4);
    check_eq("t4_b0", rx_q[r0], 8'h02);
    check_eq("t4_b1", rx_q[r0+1], 8'h61);
    check_eq("t4_b2", rx_q[r0+2], 8'h03);
    check_eq("t4_b3", rx_q[r0+3], 8'h55);

    // second rise while a packet is in flight
    d0 = drop_seen; r0 = rx_q.size();
    for (int k = 0; k < 15; k++) word[8*k +: 8] = 8'($urandom);
    len = 4'd3; fin = 1'b1;
    repeat (8) tick();
    fin = 1'b0;
    repeat (4) tick();
    fin = 1'b1;
    repeat (4) tick();
    fin = 1'b0;
    drain();
    compare_streams();
    check_eq("t5_nbytes", rx_q.size() - r0, 5);
    check_eq("t5_drops", drop_seen - d0, 1);

    // reset in the middle of a byte with letters queued
    for (int i = 0; i < 4; i++) send_letter(8'($urandom));
    repeat (8) tick();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_tx", tx, 1);
    check_eq("t6_count", fcount, 0);
    check_eq("t6_busy", busy, 0);
    repeat (3) tick();
    rst = 1'b0;
    cmp_i = 0;
    repeat (60) tick();
    check_eq("t6_rx_empty", rx_q.size(), 0);
    compare_streams();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      lv = ($urandom_range(0, 11) == 0);
      letter = 8'($urandom);
      if ($urandom_range(0, 69) == 0) begin
        fin = ~fin;
        if (fin) begin
          for (int k = 0; k < 15; k++) word[8*k +: 8] = 8'($urandom);
          len = 4'($urandom_range(0, 15));
        end
      end
      tick();
    end
    lv = 1'b0;
    fin = 1'b0;
    drain();
    compare_streams();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
